// File: rtl/rc_pkg.sv
// Shared round-constant table, FSM state type and index-clamping lookup
// for the round-constant unit.
package rc_pkg;

  localparam int NUM_RC = 12;

  localparam logic [6:0] RC_TABLE [NUM_RC] = '{
    7'h5A, 7'h34, 7'h73, 7'h66, 7'h57, 7'h35,
    7'h71, 7'h62, 7'h5F, 7'h25, 7'h51, 7'h22
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Out-of-range indices saturate to the last populated entry.
  function automatic logic [6:0] rc_lookup(input int unsigned idx, input int unsigned n);
    logic [3:0] sel;
    sel = (idx >= n) ? 4'(n - 1) : 4'(idx);
    return RC_TABLE[sel];
  endfunction

endpackage

// File: rtl/rc_lane_add.sv
// Combinational W-bit wrapping add (or subtract, when RC_INVERSE_EN is
// defined) of one state symbol with the round constant.
module rc_lane_add #(
  parameter int W = 7
) (
  input  logic [W-1:0] lane,
  input  logic [W-1:0] rc,
`ifdef RC_INVERSE_EN
  input  logic         inv,
`endif
  output logic [W-1:0] y
);

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b;
  endfunction

`ifdef RC_INVERSE_EN
  function automatic logic [W-1:0] wrap_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction

  assign y = inv ? wrap_sub(lane, rc) : wrap_add(lane, rc);
`else
  assign y = wrap_add(lane, rc);
`endif

endmodule

// File: rtl/round_constant_unit.sv
// Multi-cycle round-constant adder: LANES packed W-bit symbols, one lane per
// enabled clock. Define RC_INVERSE_EN to enable per-instruction subtract (datab[8]).
module round_constant_unit
  import rc_pkg::*;
#(
  parameter int W      = 7,
  parameter int LANES  = 4,
  parameter int NUM_RC = rc_pkg::NUM_RC,
  parameter int IDX_W  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int LW    = LANES * W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    lanes_p0;
  logic [W-1:0]     rc_p0;
  logic [LW-1:0]    result_p1;
  logic             accept;
  logic             last;
  logic [W-1:0]     lane_x;
  logic [W-1:0]     lane_y;
  logic             unused_in;

  assign accept    = clk_en && (state == ST_IDLE) && start;
  assign last      = (cnt == CNT_W'(LANES - 1));
  assign lane_x    = lanes_p0[int'(cnt) * W +: W];
  assign result    = 32'(result_p1);
  // Bits above the packed lanes and unused datab fields are don't-care.
  assign unused_in = ^{dataa, datab};

`ifdef RC_INVERSE_EN
  logic inv_p0;

  always_ff @(posedge clk)
    if (accept) inv_p0 <= datab[8];

  rc_lane_add #(.W(W)) u_lane_add (
    .lane (lane_x),
    .rc   (rc_p0),
    .inv  (inv_p0),
    .y    (lane_y)
  );
`else
  rc_lane_add #(.W(W)) u_lane_add (
    .lane (lane_x),
    .rc   (rc_p0),
    .y    (lane_y)
  );
`endif

  // p0: operand capture on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      lanes_p0 <= dataa[LW-1:0];
      rc_p0    <= W'(rc_lookup(32'(datab[IDX_W-1:0]), 32'(NUM_RC)));
    end
  end

  // p1: FSM, lane counter, result lanes and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      result_p1 <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            cnt       <= '0;
            result_p1 <= '0;
          end
        end
        ST_RUN: begin
          result_p1[int'(cnt) * W +: W] <= lane_y;
          if (last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_constant_unit.sv
// Self-checking bench for round_constant_unit: a 4-lane instance and a
// legacy single-lane instance, checked against a table-driven reference model.
module tb_round_constant_unit;

  logic        clk = 1'b0;
  logic        reset_n, clk_en;
  logic        start, start_l;
  logic [31:0] dataa, datab, dataa_l, datab_l;
  logic        done, done_l;
  logic [31:0] result, result_l;

  int vectors = 0;
  int miscompares = 0;

  int rc_tbl [12] = '{'h5A, 'h34, 'h73, 'h66, 'h57, 'h35,
                      'h71, 'h62, 'h5F, 'h25, 'h51, 'h22};

  always #5 clk = ~clk;

  round_constant_unit #(.W(7), .LANES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  round_constant_unit #(.W(7), .LANES(1)) u_leg (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start_l),
    .dataa(dataa_l), .datab(datab_l), .done(done_l), .result(result_l)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input int lanes);
    int idx, rc, lane, v;
    bit inv;
    logic [31:0] res;
    idx = int'(b[3:0]);
    if (idx >= 12) idx = 11;
    rc = rc_tbl[idx];
`ifdef RC_INVERSE_EN
    inv = b[8];
`else
    inv = 1'b0;
`endif
    res = 32'h0;
    for (int k = 0; k < lanes; k++) begin
      lane = int'((a >> (k * 7)) & 32'h7F);
      v = inv ? ((lane - rc + 128) % 128) : ((lane + rc) % 128);
      res = res | (32'(v) << (k * 7));
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input bit leg);
    return leg ? result_l : result;
  endfunction

  function automatic logic done_of(input bit leg);
    return leg ? done_l : done;
  endfunction

  task automatic run_op(input bit leg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expr, input string tag);
    int n;
    @(negedge clk);
    if (leg) begin start_l = 1'b1; dataa_l = a; datab_l = b; end
    else     begin start   = 1'b1; dataa   = a; datab   = b; end
    @(posedge clk); #1;
    start = 1'b0; start_l = 1'b0;
    chk({tag, "_clr"}, res_of(leg), 32'h0);
    n = 0;
    while (!done_of(leg) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), leg ? 32'd1 : 32'd4);
    chk({tag, "_res"}, res_of(leg), expr);
    @(posedge clk); #1;
    chk({tag, "_dfall"}, 32'(done_of(leg)), 32'h0);
    chk({tag, "_hold"}, res_of(leg), expr);
  endtask

  initial begin
    int n;
    logic [31:0] a, b, r;

    reset_n = 1'b0; clk_en = 1'b1;
    start = 1'b0; start_l = 1'b0;
    dataa = '0; datab = '0; dataa_l = '0; datab_l = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_res", result, 32'h0);
    chk("rst_res_leg", result_l, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Legacy single-lane vectors
    run_op(1'b1, 32'h10, 32'h0, 32'h6A, "leg_add");
    run_op(1'b1, 32'h7F, 32'h2, 32'h72, "leg_wrap");
    run_op(1'b1, 32'h10, 32'hF, 32'h32, "leg_clamp");

    // Multi-lane directed vector, upper bits of dataa/datab ignored
    run_op(1'b0, 32'h0080C101, 32'h1, 32'h070DDB35, "ml_dir");
    run_op(1'b0, 32'hF080C101, 32'hFFFF_FE01, model(32'h0080C101, 32'h1, 4), "ml_ign");

    // Inverse vector (addition when the feature is not built)
    run_op(1'b0, 32'h070DDB35, 32'h101, model(32'h070DDB35, 32'h101, 4), "inv");
`ifdef RC_INVERSE_EN
    chk("inv_const", result, 32'h0080C101);
`endif

    // Second start during RUN is ignored
    @(negedge clk); start = 1'b1; dataa = 32'h0080C101; datab = 32'h1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); start = 1'b1; dataa = 32'h0FFFFFFF; datab = 32'h5;
    n = 0;
    @(posedge clk); #1; n++; start = 1'b0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("rs_lat", 32'(n), 32'd4);
    chk("rs_res", result, 32'h070DDB35);
    n = 0;
    repeat (8) begin @(posedge clk); #1; if (done) n++; end
    chk("rs_pulses", 32'(n), 32'd0);
    chk("rs_hold", result, 32'h070DDB35);

    // clk_en low for 3 cycles mid-RUN delays done by 3
    a = 32'h01234567; b = 32'h7;
    @(negedge clk); start = 1'b1; dataa = a; datab = b;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    n = 1;
    @(negedge clk); clk_en = 1'b0; r = result;
    repeat (3) @(posedge clk);
    #1; n += 3;
    chk("ce_freeze_res", result, r);
    chk("ce_freeze_done", 32'(done), 32'h0);
    @(negedge clk); clk_en = 1'b1;
    while (!done && n < 30) begin @(posedge clk); #1; n++; end
    chk("ce_lat", 32'(n), 32'd7);
    chk("ce_res", result, model(a, b, 4));

    // Asynchronous reset mid-RUN abandons the operation
    @(negedge clk); start = 1'b1; dataa = 32'h0FFFFFFF; datab = 32'h3;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_res", result, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_idle", 32'(done), 32'h0);
    run_op(1'b0, 32'h0080C101, 32'h1, 32'h070DDB35, "mrst_next");

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(1'b0, a, b, model(a, b, 4), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(1'b1, a, b, model(a, b, 1), $sformatf("rndl%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_constant_unit.md
# round_constant_unit

Multi-cycle, parametrised round-constant adder for the cipher's Nios II custom-instruction path. It is the successor to the single-lane combinational 7-bit constant adder. Each instruction processes LANES packed W-bit state symbols, one lane per clock, under a start/done handshake. It optionally supports an inverse (subtract) mode for decryption.

## Interface
- W, 7: symbol width in bits; LANES*W ≤ 32.
- LANES, 4: symbols packed in dataa, lane k at bits [k*W +: W].
- NUM_RC, 12: number of round constants in the shared table.
- IDX_W, 4: width of the round-index field in datab.
- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- clk_en  in  1  custom-instruction clock enable; low freezes all state.
- start  in  1  instruction start; sampled in IDLE only.
- dataa  in  32  packed lanes; bits ≥ LANES*W are ignored.
- datab  in  32  [IDX_W-1:0] is the round index; bit 8 is inverse select (RC_INVERSE_EN only); other bits are ignored.
- done  out  1  one-cycle pulse; result is valid while done is high and is held afterwards.
- result  out  32  packed processed lanes; bits ≥ LANES*W are zero.

## Operation
- States: IDLE and RUN.
- IDLE:
  - On start with clk_en high: latch dataa and datab.
  - Resolve the constant: rc = RC_TABLE[idx], where idx = datab[IDX_W-1:0]. If idx ≥ NUM_RC, use RC_TABLE[NUM_RC-1].
  - Clear the lane counter and go to RUN.
- RUN: each enabled cycle, result lane[cnt] = (lane[cnt] + rc) mod 2^W, then cnt increments.
- After lane LANES-1 is written: assert done and return to IDLE.
- All lanes in one instruction use the same rc.
- Arithmetic is W-bit and wraps; carry is discarded.
- Inverse (with RC_INVERSE_EN and datab[8]=1): lane = (lane − rc) mod 2^W.
- start asserted in RUN is ignored and does not restart the operation.
- result is held from done until the next accepted start. On a new start, result clears to 0 and lanes are refilled one per cycle.
- clk_en low: FSM, counter, result and done all hold their values.
- reset_n low at any time, including mid-RUN: state = IDLE, cnt = 0, result = 0, done = 0. The in-flight operation is abandoned.

## Timing
- Reset values: done = 0, result = 32'h0, state = IDLE.
- start is accepted at edge E0. Lane k is written at edge E(k+1).
- done is registered. It goes high at edge E(LANES) and low at E(LANES+1).
- Latency is LANES cycles from the start edge to done.
- A back-to-back start is accepted at the edge where done falls (state is IDLE). Throughput is 1 instruction per LANES+1 cycles.
- All cycle counts are in enabled cycles (clk_en high).

## Configuration
- RC_INVERSE_EN:
  - Defined: datab[8] selects subtract mode per instruction.
  - Undefined: datab[8] is ignored, only addition is implemented, and the subtractor logic is absent.

## Structure
- Package rc_pkg holds:
  - NUM_RC.
  - The RC_TABLE constant array: 7'h5A, 7'h34, 7'h73, 7'h66, 7'h57, 7'h35, 7'h71, 7'h62, 7'h5F, 7'h25, 7'h51, 7'h22. Entries are zero-extended or truncated to W.
  - The FSM state enum.
- One sub-module, rc_lane_add: combinational W-bit add/sub of one lane with rc, plus the inverse select. It is instantiated once and time-multiplexed by cnt.

## Test plan
- Reset: hold reset_n low → done = 0 and result = 0. Assert reset_n low mid-RUN → both clear immediately, and the next start runs normally.
- Legacy (LANES=1, W=7): dataa = 0x10, datab = 0 → result = 0x6A, with done one cycle after start. dataa = 0x7F, datab = 2 → result = 0x72 (wrap). datab = 15 → +0x22 (clamp).
- Multi-lane (LANES=4): dataa = 0x0080C101 (lanes 1, 2, 3, 4), datab = 1 → result = 0x070DDB35. done rises exactly 4 cycles after start and lasts 1 cycle.
- Handshake: a second start during RUN → ignored, result matches the first operation, and exactly one done pulse occurs. Holding clk_en low for 3 cycles mid-RUN → done is delayed by 3 cycles.
- Inverse (RC_INVERSE_EN, LANES=4): dataa = 0x070DDB35, datab = 0x101 → result = 0x0080C101. With the macro undefined, the same stimulus → addition result.
